// File: rtl/prach_pkg.sv
// Constants shared by the PRACH decimation chain (hb4 polyphase splitter and halfband filter).
package prach_pkg;

  localparam int unsigned NumChannel     = 128;
  localparam int unsigned NumChannelUsed = 48;
  localparam int unsigned DataW          = 16;

  typedef logic [DataW-1:0] sample_t;

endpackage

// File: rtl/prach_delay.sv
// Fixed-length shift-register delay with asynchronous active-low reset.
module prach_delay #(
  parameter int unsigned Delay = 2,
  parameter int unsigned Width = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [Width-1:0] din,
  output logic [Width-1:0] dout
);

  logic [Width-1:0] pipe_q [Delay];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q <= '{default: '0};
    end else begin
      pipe_q[0] <= din;
      for (int unsigned i = 1; i < Delay; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign dout = pipe_q[Delay-1];

endmodule

// File: rtl/prach_sdp_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-before-write on collision).
module prach_sdp_ram #(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 48,
  parameter int unsigned AddrW = 6
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AddrW-1:0] waddr,
  input  logic [Width-1:0] wdata,
  input  logic [AddrW-1:0] raddr,
  output logic [Width-1:0] rdata
);

  logic [Width-1:0] mem_q [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/prach_hb4_pp.sv
// Pairs consecutive samples of each TDM channel into even/odd (dp1/dp2) pairs for hb4.
module prach_hb4_pp
  import prach_pkg::*;
#(
  parameter int unsigned NUM_CHANNEL      = NumChannel,
  parameter int unsigned NUM_CHANNEL_USED = NumChannelUsed,
  parameter int unsigned DATA_W           = DataW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din_dq,
  input  logic              din_dv,
  input  logic [7:0]        din_chn,
  input  logic              sync_in,
  output logic [DATA_W-1:0] dout_dp1,
  output logic [DATA_W-1:0] dout_dp2,
  output logic              dout_dv,
  output logic [7:0]        dout_chn,
  output logic              sync_out
);

  localparam int unsigned ChnUsed = (NUM_CHANNEL_USED < NUM_CHANNEL) ? NUM_CHANNEL_USED
                                                                     : NUM_CHANNEL;
  localparam int unsigned AddrW   = $clog2(ChnUsed);
  localparam int unsigned PhN     = 1 << AddrW;
  localparam logic [7:0]  ChnLim  = 8'(ChnUsed);

  logic              acc;
  logic [AddrW-1:0]  addr;
  logic              ph_rd;
  logic [PhN-1:0]    ph_q, ph_d;

  logic [DATA_W-1:0] s1_dq;
  logic [7:0]        s1_chn;
  logic [AddrW-1:0]  s1_addr;
  logic              s1_acc, s1_ph, s1_fwd;
  logic [DATA_W-1:0] s1_fwd_dq;

  logic              wr_en, pair, fwd;
  logic [DATA_W-1:0] ram_rdata, even_dq;

  assign acc     = din_dv && (din_chn < ChnLim);
  assign addr    = din_chn[AddrW-1:0];
  assign s1_addr = s1_chn[AddrW-1:0];

  // An even sample in stage 2 is dropped when sync arrives alongside it.
  assign wr_en   = s1_acc && !s1_ph && !sync_in;
  assign pair    = s1_acc && s1_ph;
  assign fwd     = wr_en && (s1_addr == addr);
  assign even_dq = s1_fwd ? s1_fwd_dq : ram_rdata;

  // Phase lookup sees the stage-2 update of the same channel before it lands in ph_q.
  always_comb begin
    ph_rd = ph_q[addr];
    if (s1_acc && (s1_addr == addr)) begin
      ph_rd = ~s1_ph;
    end
    if (sync_in) begin
      ph_rd = 1'b0;
    end
  end

  always_comb begin
    ph_d = ph_q;
    if (sync_in) begin
      ph_d = '0;
    end else if (s1_acc) begin
      ph_d[s1_addr] = ~s1_ph;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ph_q      <= '0;
      s1_dq     <= '0;
      s1_chn    <= '0;
      s1_acc    <= 1'b0;
      s1_ph     <= 1'b0;
      s1_fwd    <= 1'b0;
      s1_fwd_dq <= '0;
    end else begin
      ph_q      <= ph_d;
      s1_dq     <= din_dq;
      s1_chn    <= din_chn;
      s1_acc    <= acc;
      s1_ph     <= ph_rd;
      s1_fwd    <= fwd;
      s1_fwd_dq <= s1_dq;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_dv  <= 1'b0;
      dout_dp1 <= '0;
      dout_dp2 <= '0;
      dout_chn <= '0;
    end else begin
      dout_dv <= pair;
      if (pair) begin
        dout_dp1 <= even_dq;
        dout_dp2 <= s1_dq;
        dout_chn <= s1_chn;
      end
    end
  end

  prach_sdp_ram #(
    .Width(DATA_W),
    .Depth(ChnUsed),
    .AddrW(AddrW)
  ) u_ram (
    .clk  (clk),
    .we   (wr_en),
    .waddr(s1_addr),
    .wdata(s1_dq),
    .raddr(addr),
    .rdata(ram_rdata)
  );

  prach_delay #(
    .Delay(2),
    .Width(1)
  ) u_sync_dly (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sync_in),
    .dout (sync_out)
  );

endmodule

// File: tb/tb_prach_hb4_pp.sv
// Scoreboard bench for prach_hb4_pp against a per-channel pending-sample reference model.
module tb_prach_hb4_pp;

  localparam int NumUsed = 48;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] din_dq;
  logic        din_dv;
  logic [7:0]  din_chn;
  logic        sync_in;
  logic [15:0] dout_dp1, dout_dp2;
  logic        dout_dv;
  logic [7:0]  dout_chn;
  logic        sync_out;

  prach_hb4_pp dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din_dq  (din_dq),
    .din_dv  (din_dv),
    .din_chn (din_chn),
    .sync_in (sync_in),
    .dout_dp1(dout_dp1),
    .dout_dp2(dout_dp2),
    .dout_dv (dout_dv),
    .dout_chn(dout_chn),
    .sync_out(sync_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dp1;
    logic [15:0] dp2;
    logic [7:0]  chn;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          sync_log [65536];
  bit          pending [NumUsed];
  logic [15:0] stored [NumUsed];
  exp_t        last_out;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a channel either holds one pending even sample or nothing.
  task automatic step(input bit dv, input int chn, input logic [15:0] dq, input bit sy);
    exp_t e;
    @(negedge clk);
    din_dv  = dv;
    din_chn = chn[7:0];
    din_dq  = dq;
    sync_in = sy;
    sync_log[cyc] = sy;
    if (sy) begin
      for (int c = 0; c < NumUsed; c++) pending[c] = 1'b0;
    end
    if (dv && chn < NumUsed) begin
      if (pending[chn]) begin
        e.dp1 = stored[chn];
        e.dp2 = dq;
        e.chn = chn[7:0];
        e.due = cyc + 2;
        exp_q.push_back(e);
        pending[chn] = 1'b0;
      end else begin
        pending[chn] = 1'b1;
        stored[chn]  = dq;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 16'h0, 1'b0);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n   = 1'b0;
    din_dv  = 1'b0;
    sync_in = 1'b0;
    sync_log[cyc] = 1'b0;
    for (int c = 0; c < NumUsed; c++) pending[c] = 1'b0;
    exp_q.delete();
    idle(n);
    @(negedge clk);
    sync_log[cyc] = 1'b0;
    rst_n = 1'b1;
  endtask

  // Monitor: checks outputs just after each falling edge.
  always @(negedge clk) begin
    exp_t e;
    #1;
    if (!rst_n) begin
      chk("reset_outputs", {dout_dv, sync_out, dout_chn, dout_dp1 | dout_dp2}, 32'h0);
      last_out = '{dp1: 16'h0, dp2: 16'h0, chn: 8'h0, due: 0};
    end else begin
      chk("sync_out", 32'(sync_out), 32'((cyc >= 2) ? sync_log[cyc-2] : 1'b0));
      if (dout_dv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", {dout_chn, 8'h0, dout_dp1}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("pair_dp1", 32'(dout_dp1), 32'(e.dp1));
          chk("pair_dp2", 32'(dout_dp2), 32'(e.dp2));
          chk("pair_chn", 32'(dout_chn), 32'(e.chn));
          chk("pair_latency", 32'(cyc), 32'(e.due));
          last_out = e;
        end
      end else begin
        if (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
          e = exp_q.pop_front();
          chk("missing_pair_chn", 32'hFFFF_FFFF, 32'(e.chn));
        end
        chk("hold_outputs", {dout_dp1, dout_dp2} ^ 32'(dout_chn),
            {last_out.dp1, last_out.dp2} ^ 32'(last_out.chn));
      end
    end
  end

  initial begin
    int chn;
    rst_n   = 1'b0;
    din_dv  = 1'b0;
    din_chn = 8'h0;
    din_dq  = 16'h0;
    sync_in = 1'b0;
    for (int c = 0; c < NumUsed; c++) begin
      pending[c] = 1'b0;
      stored[c]  = 16'h0;
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Single pair on channel 0.
    step(1'b1, 0, 16'd100, 1'b0);
    step(1'b1, 0, 16'd200, 1'b0);
    idle(4);

    // Two round-robin passes across all used channels.
    for (int c = 0; c < NumUsed; c++) step(1'b1, c, 16'(1000 + c), 1'b0);
    for (int c = 0; c < NumUsed; c++) step(1'b1, c, 16'(2000 + c), 1'b0);
    idle(4);

    // Out-of-range channel between an even/odd pair.
    step(1'b1, 5, 16'd7, 1'b0);
    step(1'b1, 60, 16'd1234, 1'b0);
    step(1'b1, 5, 16'd9, 1'b0);
    idle(4);

    // Pending even sample discarded by sync.
    step(1'b1, 3, 16'h8000, 1'b0);
    step(1'b0, 0, 16'h0, 1'b1);
    step(1'b1, 3, 16'd11, 1'b0);
    step(1'b1, 3, 16'd22, 1'b0);
    idle(4);

    // Sync coinciding with back-to-back samples of one channel.
    step(1'b1, 9, 16'd1, 1'b0);
    step(1'b1, 9, 16'd2, 1'b1);
    step(1'b1, 9, 16'd3, 1'b0);
    idle(4);

    // Reset while channel 1 holds an even sample.
    step(1'b1, 1, 16'd77, 1'b0);
    do_reset(3);
    step(1'b1, 1, 16'd5, 1'b0);
    step(1'b1, 1, 16'd6, 1'b0);
    idle(4);

    // Randomised traffic: gaps, repeats, out-of-range channels, occasional sync.
    chn = 0;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) step(1'b0, 0, 16'($urandom), ($urandom_range(0, 199) == 0));
      if ($urandom_range(0, 9) < 4) chn = int'($urandom_range(0, 63));
      step(1'b1, chn, 16'($urandom), ($urandom_range(0, 199) == 0));
    end
    idle(6);

    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
